// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants and register-file sizing helpers
package cpu_pkg;

    localparam int CPU_XLEN     = 32;
    localparam int CPU_NREGS    = 32;
    localparam int CPU_ILEN     = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    typedef logic [CPU_XLEN-1:0] word_t;

    // Address width for a power-of-two register count (n >= 2).
    function automatic int reg_aw(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with set-over-clear priority
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = CPU_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = reg_aw(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWR-1:0]          we,
    input  logic [NWR-1:0][AW-1:0]  waddr,
    input  logic                    sb_set,
    input  logic [AW-1:0]           sb_addr,
    input  logic [NRD-1:0][AW-1:0]  raddr,
    output logic [NRD-1:0]          rbusy
);

    logic [NREGS-1:0] r_pending;
    logic [NRD-1:0]   w_wr_hit;

    // A newly issued producer outranks a write retiring the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (waddr[i] != '0)) begin
                    r_pending[waddr[i]] <= 1'b0;
                end
            end
            if (sb_set && (sb_addr != '0)) begin
                r_pending[sb_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_wr_hit = '0;
        rbusy    = '0;
        for (int j = 0; j < NRD; j++) begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (waddr[i] == raddr[j])) begin
                    w_wr_hit[j] = 1'b1;
                end
            end
            rbusy[j] = !rst && (raddr[j] != '0) && r_pending[raddr[j]] && !w_wr_hit[j];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port flip-flop register file with write bypass and scoreboard
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int XLEN  = CPU_XLEN,
    parameter int NREGS = CPU_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = reg_aw(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   waddr,
    input  logic [NWR-1:0][XLEN-1:0] wdata,
    input  logic [NRD-1:0][AW-1:0]   raddr,
    output logic [NRD-1:0][XLEN-1:0] rdata,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_addr,
    output logic [NRD-1:0]           rbusy
);

    logic [XLEN-1:0] r_regs [NREGS];

    // Loop order makes the highest-numbered write port win on address collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (waddr[i] != '0)) begin
                    r_regs[waddr[i]] <= wdata[i];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < NRD; j++) begin
            if (raddr[j] != '0) begin
                rdata[j] = r_regs[raddr[j]];
                for (int i = 0; i < NWR; i++) begin
                    if (we[i] && (waddr[i] == raddr[j])) begin
                        rdata[j] = wdata[i];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .raddr   (raddr),
        .rbusy   (rbusy)
    );

endmodule
